ejtag_dma_master: RTL and testbench
===================================

// Module: ejtag_dma_master
// PURPOSE
//  EJTAG DMA bus master in the CORE_CLOCK domain. Takes the one-cycle DMA start pulse and the DMA attributes
//  from ejtag_control, then runs a single-beat read or write on the system bus.
//  On completion it pulses EJD_EVAL (wired to LBC_EVAL), which clears ECR.DSTRT.
//  It returns read data, the error status and the post-increment address to the JTAG data/address registers.
// PARAMETERS
//  TIMEOUT   255  max CORE_CLOCK cycles from leaving IDLE to BUS_ACK/BUS_ERR; 8-bit counter
// PORTS
//  CORE_CLOCK      in   1   block clock
//  RESET_D1_R_N    in   1   async active-low reset
//  EJC_DMASTART    in   1   one-cycle start pulse
//  EJC_DMAREAD     in   1   1=read, 0=write; sampled with start
//  EJC_DMASIZE     in   2   00 byte, 01 half, 10 word, 11 reserved; sampled with start
//  EJC_DMAINC      in   1   post-increment address on success; sampled with start
//  EJSN_ADDR       in   32  DMA address from JTAG address register; sampled with start
//  EJSN_DATA       in   32  write data, right-justified; sampled with start
//  DMA_REQ         out  1   bus request, held until BUS_GNT
//  BUS_GNT         in   1   bus grant
//  DMA_VALID       out  1   address/data phase valid
//  DMA_RD          out  1   1=read cycle
//  DMA_ADDR        out  32  word-aligned address {addr[31:2],2'b00}
//  DMA_BE          out  4   byte enables, little-endian lanes
//  DMA_WDATA       out  32  write data, replicated across lanes
//  BUS_ACK         in   1   transfer complete; BUS_RDATA valid
//  BUS_ERR         in   1   bus error; terminates the transfer
//  BUS_RDATA       in   32  read data
//  EJD_EVAL        out  1   one-cycle completion pulse, success or error
//  EJD_RDATA       out  32  read result, right-justified and zero-extended
//  EJD_DERR        out  1   sticky error of the last transfer
//  EJD_ADDR_NEXT   out  32  address after the transfer
//  EJD_BUSY        out  1   high when state != IDLE
// BEHAVIOUR
//  Reset values: all outputs 0. EJD_RDATA, EJD_ADDR_NEXT and EJD_DERR are 0. State is IDLE.
//  States: IDLE -> CHK -> REQ -> XFER -> DONE -> IDLE.
//  IDLE: when EJC_DMASTART=1, capture every attribute, clear EJD_DERR and the timeout counter, go to CHK.
//   EJC_DMASTART outside IDLE is ignored (no queueing).
//  CHK (1 cycle): compute the BE and the alignment check.
//   Byte: BE = 4'b0001 << a[1:0].
//   Half: a[0] must be 0; BE = a[1] ? 1100 : 0011.
//   Word: a[1:0] must be 00; BE = 1111.
//   A misaligned access or size 11 sets DERR and goes to DONE with no bus activity.
//  REQ: DMA_REQ=1 until BUS_GNT=1, then go to XFER.
//   Grant in the same cycle REQ is entered counts.
//  XFER: DMA_VALID=1 with DMA_RD, DMA_ADDR, DMA_BE and DMA_WDATA held stable.
//   Write data: byte replicated x4, half replicated x2, word as is.
//   BUS_ACK: on a read, shift the selected lanes down into EJD_RDATA and zero-fill the rest; go to DONE.
//   BUS_ERR: set DERR, leave EJD_RDATA unchanged, go to DONE.
//   BUS_ERR takes priority over BUS_ACK when both arrive in the same cycle.
//  Timeout: the counter increments every cycle in CHK, REQ and XFER.
//   Reaching TIMEOUT sets DERR, drops DMA_REQ/DMA_VALID and goes to DONE.
//  DONE (1 cycle): assert EJD_EVAL.
//   EJD_ADDR_NEXT = addr + {1,2,4} (32-bit wrap at FFFF_FFFF) if INC and no error; otherwise addr.
//   Then go to IDLE.
//   Latency: start to EVAL = 4 cycles minimum (grant in the same cycle, ack on the first XFER cycle).
//  Reset mid-transfer: asynchronous return to IDLE, DMA_REQ/DMA_VALID deassert immediately, no EVAL.
//  Back-to-back: a start pulse in the cycle after DONE (state IDLE) is accepted.
// TESTING
//  Word write, addr 0x1000_0000, data 0xA5A5_5A5A, INC=1, grant+ack immediate
//   -> BE=1111, EVAL 4 cycles after start, ADDR_NEXT=0x1000_0004, DERR=0.
//  Byte read, addr 0x0000_0003, BUS_RDATA=0x11223344
//   -> BE=1000, RDATA=0x0000_0011.
//  Half read at addr 0x2; then half write at addr 0x1
//   -> first: BE=1100; second: DERR=1, no DMA_REQ, EVAL, ADDR_NEXT=0x1.
//  Word write, addr 0xFFFF_FFFC, INC=1 -> ADDR_NEXT=0x0000_0000.
//  BUS_ERR and BUS_ACK asserted together; separately, grant withheld -> both give DERR=1.
//   Grant withheld: DMA_REQ drops and EVAL fires on cycle TIMEOUT.
//  Reset asserted during XFER -> outputs 0 asynchronously.
//   After release, a new start completes normally; a start pulse during BUSY is ignored.

Source files
------------

// File: rtl/ejtag_dma_master_if.sv
// System-bus side of the EJTAG DMA master: request/grant arbitration plus a single-beat
// address/data phase.
// Handshake: DMA_REQ stays high until BUS_GNT is sampled high; DMA_VALID then holds
// DMA_RD/ADDR/BE/WDATA stable until BUS_ACK or BUS_ERR is sampled high, and BUS_RDATA is
// only meaningful with BUS_ACK.
interface ejtag_dma_master_if;
  logic        DMA_REQ;
  logic        BUS_GNT;
  logic        DMA_VALID;
  logic        DMA_RD;
  logic [31:0] DMA_ADDR;
  logic [3:0]  DMA_BE;
  logic [31:0] DMA_WDATA;
  logic        BUS_ACK;
  logic        BUS_ERR;
  logic [31:0] BUS_RDATA;

  modport master (
    output DMA_REQ, DMA_VALID, DMA_RD, DMA_ADDR, DMA_BE, DMA_WDATA,
    input  BUS_GNT, BUS_ACK, BUS_ERR, BUS_RDATA
  );

  modport slave (
    input  DMA_REQ, DMA_VALID, DMA_RD, DMA_ADDR, DMA_BE, DMA_WDATA,
    output BUS_GNT, BUS_ACK, BUS_ERR, BUS_RDATA
  );
endinterface

// File: rtl/ejtag_dma_master.sv
// EJTAG DMA bus master: one single-beat read or write per start pulse, with alignment
// checking, a bus timeout, and a one-cycle completion pulse back to the JTAG side.
module ejtag_dma_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        CORE_CLOCK,
  input  logic        RESET_D1_R_N,
  input  logic        EJC_DMASTART,
  input  logic        EJC_DMAREAD,
  input  logic [1:0]  EJC_DMASIZE,
  input  logic        EJC_DMAINC,
  input  logic [31:0] EJSN_ADDR,
  input  logic [31:0] EJSN_DATA,
  ejtag_dma_master_if.master bus,
  output logic        EJD_EVAL,
  output logic [31:0] EJD_RDATA,
  output logic        EJD_DERR,
  output logic [31:0] EJD_ADDR_NEXT,
  output logic        EJD_BUSY,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CHK  = 3'd1,
    S_REQ  = 3'd2,
    S_XFER = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0] L_CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_read;
  logic [1:0]  r_size;
  logic        r_inc;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_req;
  logic        r_valid;
  logic [7:0]  r_cnt;
  logic        r_eval;
  logic [31:0] r_rdata;
  logic        r_derr;
  logic [31:0] r_addr_next;

  logic [3:0]  w_be;
  logic        w_misalign;
  logic        w_timeout;
  logic [31:0] w_shift;
  logic [31:0] w_rd_sel;
  logic [31:0] w_step;
  logic [31:0] w_wdata_cap;
  logic        w_done;
  logic        w_err;

  always_comb begin
    w_be       = 4'b0000;
    w_misalign = 1'b0;
    w_step     = 32'd0;
    case (r_size)
      2'b00: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_step = 32'd1;
      end
      2'b01: begin
        w_be       = r_addr[1] ? 4'b1100 : 4'b0011;
        w_misalign = r_addr[0];
        w_step     = 32'd2;
      end
      2'b10: begin
        w_be       = 4'b1111;
        w_misalign = (r_addr[1:0] != 2'b00);
        w_step     = 32'd4;
      end
      default: w_misalign = 1'b1;
    endcase
  end

  // Addressed lanes are shifted down to bit 0; a legal half/word address keeps the shift in range.
  always_comb begin
    w_shift  = bus.BUS_RDATA >> {r_addr[1:0], 3'b000};
    w_rd_sel = w_shift;
    case (r_size)
      2'b00:   w_rd_sel = {24'h0, w_shift[7:0]};
      2'b01:   w_rd_sel = {16'h0, w_shift[15:0]};
      default: w_rd_sel = w_shift;
    endcase
  end

  always_comb begin
    case (EJC_DMASIZE)
      2'b00:   w_wdata_cap = {4{EJSN_DATA[7:0]}};
      2'b01:   w_wdata_cap = {2{EJSN_DATA[15:0]}};
      default: w_wdata_cap = EJSN_DATA;
    endcase
  end

  assign w_timeout = (r_cnt == L_CNT_LAST);

  // Which busy-state exits end the transfer, and whether they end it in error.
  always_comb begin
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      S_CHK: begin
        w_done = w_misalign;
        w_err  = w_misalign;
      end
      S_REQ: begin
        w_done = w_timeout;
        w_err  = w_timeout;
      end
      S_XFER: begin
        w_done = bus.BUS_ERR | bus.BUS_ACK | w_timeout;
        w_err  = bus.BUS_ERR | (~bus.BUS_ACK & w_timeout);
      end
      default: begin
        w_done = 1'b0;
        w_err  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CORE_CLOCK or negedge RESET_D1_R_N) begin
    if (!RESET_D1_R_N) begin
      r_state     <= S_IDLE;
      r_read      <= 1'b0;
      r_size      <= 2'b00;
      r_inc       <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_be        <= 4'h0;
      r_req       <= 1'b0;
      r_valid     <= 1'b0;
      r_cnt       <= 8'h0;
      r_eval      <= 1'b0;
      r_rdata     <= 32'h0;
      r_derr      <= 1'b0;
      r_addr_next <= 32'h0;
    end else begin
      r_eval <= 1'b0;
      if (r_state == S_CHK || r_state == S_REQ || r_state == S_XFER)
        r_cnt <= r_cnt + 8'd1;
      if (r_state == S_XFER && bus.BUS_ACK && !bus.BUS_ERR && r_read)
        r_rdata <= w_rd_sel;

      if (w_done) begin
        r_state     <= S_DONE;
        r_req       <= 1'b0;
        r_valid     <= 1'b0;
        r_eval      <= 1'b1;
        r_derr      <= w_err;
        r_addr_next <= (r_inc && !w_err) ? r_addr + w_step : r_addr;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (EJC_DMASTART) begin
              r_read  <= EJC_DMAREAD;
              r_size  <= EJC_DMASIZE;
              r_inc   <= EJC_DMAINC;
              r_addr  <= EJSN_ADDR;
              r_wdata <= w_wdata_cap;
              r_derr  <= 1'b0;
              r_cnt   <= 8'h0;
              r_state <= S_CHK;
            end
          end
          S_CHK: begin
            r_be    <= w_be;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
          S_REQ: begin
            if (bus.BUS_GNT) begin
              r_req   <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_XFER;
            end
          end
          S_XFER:  r_state <= S_XFER;
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.DMA_REQ   = r_req;
  assign bus.DMA_VALID = r_valid;
  assign bus.DMA_RD    = r_read;
  assign bus.DMA_ADDR  = {r_addr[31:2], 2'b00};
  assign bus.DMA_BE    = r_be;
  assign bus.DMA_WDATA = r_wdata;

  assign EJD_EVAL      = r_eval;
  assign EJD_RDATA     = r_rdata;
  assign EJD_DERR      = r_derr;
  assign EJD_ADDR_NEXT = r_addr_next;
  assign EJD_BUSY      = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ejtag_dma_master.sv
// Directed bench for ejtag_dma_master: a table of single transfers with hand-computed
// results, plus reset-during-transfer and ignored-start sequences.
module tb_ejtag_dma_master;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        rd;
  logic [1:0]  size;
  logic        inc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        eval;
  logic [31:0] rdata;
  logic        derr;
  logic [31:0] addr_next;
  logic        busy;
  logic [2:0]  dbg_state;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  ejtag_dma_master_if bus_if ();

  ejtag_dma_master #(.TIMEOUT(255)) dut (
    .CORE_CLOCK    (clk),
    .RESET_D1_R_N  (rst_n),
    .EJC_DMASTART  (start),
    .EJC_DMAREAD   (rd),
    .EJC_DMASIZE   (size),
    .EJC_DMAINC    (inc),
    .EJSN_ADDR     (addr),
    .EJSN_DATA     (wdata),
    .bus           (bus_if),
    .EJD_EVAL      (eval),
    .EJD_RDATA     (rdata),
    .EJD_DERR      (derr),
    .EJD_ADDR_NEXT (addr_next),
    .EJD_BUSY      (busy),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [1:0]  size;
    logic        inc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        ack;
    logic        err;
    logic [31:0] bus_rdata;
    logic        exp_req;
    logic        exp_xfer;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_derr;
    logic [31:0] exp_next;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_start(input logic r, input logic [1:0] s, input logic i,
                             input logic [31:0] a, input logic [31:0] d);
    start = 1'b1;
    rd    = r;
    size  = s;
    inc   = i;
    addr  = a;
    wdata = d;
  endtask

  // Latency counts clock edges from the one that samples start to the one that raises EVAL.
  task automatic run_vec(input int idx, input vec_t v);
    int          lat;
    logic        req_seen;
    logic        xfer_seen;
    logic [3:0]  be_seen;
    logic [31:0] wd_seen;
    logic [31:0] ad_seen;
    logic        rd_seen;
    logic [31:0] exp_rd;
    req_seen  = 1'b0;
    xfer_seen = 1'b0;
    be_seen   = 4'h0;
    wd_seen   = 32'h0;
    ad_seen   = 32'h0;
    rd_seen   = 1'b0;
    exp_q.push_back(v.exp_rdata);
    bus_if.BUS_GNT   = v.gnt;
    bus_if.BUS_ACK   = v.ack;
    bus_if.BUS_ERR   = v.err;
    bus_if.BUS_RDATA = v.bus_rdata;
    drive_start(v.rd, v.size, v.inc, v.addr, v.wdata);
    step();
    start = 1'b0;
    lat = 1;
    while (!eval && lat < 400) begin
      if (bus_if.DMA_REQ) req_seen = 1'b1;
      if (bus_if.DMA_VALID) begin
        xfer_seen = 1'b1;
        be_seen   = bus_if.DMA_BE;
        wd_seen   = bus_if.DMA_WDATA;
        ad_seen   = bus_if.DMA_ADDR;
        rd_seen   = bus_if.DMA_RD;
      end
      step();
      lat++;
    end
    exp_rd = exp_q.pop_front();
    chk($sformatf("v%0d_eval", idx), 32'(eval), 32'd1);
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_derr", idx), 32'(derr), 32'(v.exp_derr));
    chk($sformatf("v%0d_rdata", idx), rdata, exp_rd);
    chk($sformatf("v%0d_addr_next", idx), addr_next, v.exp_next);
    chk($sformatf("v%0d_req_seen", idx), 32'(req_seen), 32'(v.exp_req));
    chk($sformatf("v%0d_xfer_seen", idx), 32'(xfer_seen), 32'(v.exp_xfer));
    chk($sformatf("v%0d_req_at_eval", idx), 32'(bus_if.DMA_REQ), 32'd0);
    chk($sformatf("v%0d_valid_at_eval", idx), 32'(bus_if.DMA_VALID), 32'd0);
    if (v.exp_xfer) begin
      chk($sformatf("v%0d_be", idx), 32'(be_seen), 32'(v.exp_be));
      chk($sformatf("v%0d_bus_addr", idx), ad_seen, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_bus_rd", idx), 32'(rd_seen), 32'(v.rd));
      if (!v.rd) chk($sformatf("v%0d_wdata", idx), wd_seen, v.exp_wdata);
    end
    step();
    chk($sformatf("v%0d_eval_one_cycle", idx), 32'(eval), 32'd0);
    chk($sformatf("v%0d_idle_after", idx), 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    rd       = 1'b0;
    size     = 2'b00;
    inc      = 1'b0;
    addr     = 32'h0;
    wdata    = 32'h0;
    bus_if.BUS_GNT   = 1'b0;
    bus_if.BUS_ACK   = 1'b0;
    bus_if.BUS_ERR   = 1'b0;
    bus_if.BUS_RDATA = 32'h0;

    //          rd  sz    inc addr          wdata         gnt ack err bus_rdata     req xfer be     exp_wdata     exp_rdata     derr next          lat
    vecs[0]  = '{1'b0, 2'd2, 1'b1, 32'h1000_0000, 32'hA5A5_5A5A, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0, 32'h1000_0004, 4};
    vecs[1]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0003, 32'h0,         1'b1, 1'b1, 1'b0, 32'h1122_3344, 1'b1, 1'b1, 4'h8, 32'h0,         32'h0000_0011, 1'b0, 32'h0000_0003, 4};
    vecs[2]  = '{1'b1, 2'd1, 1'b1, 32'h0000_0002, 32'h0,         1'b1, 1'b1, 1'b0, 32'hAABB_CCDD, 1'b1, 1'b1, 4'hC, 32'h0,         32'h0000_AABB, 1'b0, 32'h0000_0004, 4};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0001, 32'h0000_BEEF, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0000_AABB, 1'b1, 32'h0000_0001, 2};
    vecs[4]  = '{1'b0, 2'd2, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 4'hF, 32'h1234_5678, 32'h0000_AABB, 1'b0, 32'h0000_0000, 4};
    vecs[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0000_125A, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 4'h4, 32'h5A5A_5A5A, 32'h0000_AABB, 1'b0, 32'h0000_0003, 4};
    vecs[6]  = '{1'b0, 2'd3, 1'b1, 32'h0000_0000, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         32'h0000_AABB, 1'b1, 32'h0000_0000, 2};
    vecs[7]  = '{1'b1, 2'd2, 1'b1, 32'h0000_0008, 32'h0,         1'b1, 1'b1, 1'b1, 32'h0000_0099, 1'b1, 1'b1, 4'hF, 32'h0,         32'h0000_AABB, 1'b1, 32'h0000_0008, 4};
    vecs[8]  = '{1'b1, 2'd1, 1'b1, 32'h0000_0000, 32'h0,         1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 4'h3, 32'h0,         32'h0000_5678, 1'b0, 32'h0000_0002, 4};
    vecs[9]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0, 32'h0000_0010, 4};
    vecs[10] = '{1'b1, 2'd0, 1'b1, 32'h0000_0001, 32'h0,         1'b1, 1'b1, 1'b0, 32'h1122_3344, 1'b1, 1'b1, 4'h2, 32'h0,         32'h0000_0033, 1'b0, 32'h0000_0002, 4};
    // Grant withheld: 255 busy cycles elapse, then DONE on the following edge.
    vecs[11] = '{1'b0, 2'd2, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0,         32'h0000_0033, 1'b1, 32'h0000_0020, 256};

    repeat (3) step();
    chk("rst_eval", 32'(eval), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_derr", 32'(derr), 32'd0);
    chk("rst_addr_next", addr_next, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(bus_if.DMA_REQ), 32'd0);
    chk("rst_valid", 32'(bus_if.DMA_VALID), 32'd0);
    chk("rst_be", 32'(bus_if.DMA_BE), 32'd0);
    rst_n = 1'b1;
    step();

    // Consecutive vectors start in the cycle right after DONE.
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset asserted while the data phase is open.
    bus_if.BUS_GNT = 1'b1;
    bus_if.BUS_ACK = 1'b0;
    bus_if.BUS_ERR = 1'b0;
    drive_start(1'b0, 2'd2, 1'b1, 32'h0000_0030, 32'h0BAD_0BAD);
    step();
    start = 1'b0;
    lat = 0;
    while (!bus_if.DMA_VALID && lat < 10) begin
      step();
      lat++;
    end
    chk("mid_valid_reached", 32'(bus_if.DMA_VALID), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus_if.DMA_VALID), 32'd0);
    chk("mid_rst_req", 32'(bus_if.DMA_REQ), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_addr_next", addr_next, 32'h0);
    chk("mid_rst_state", 32'(dbg_state), 32'd0);
    step();
    chk("mid_rst_no_eval", 32'(eval), 32'd0);
    rst_n = 1'b1;
    step();

    // Normal transfer after reset, with a second start pulse while busy that must be dropped.
    bus_if.BUS_ACK = 1'b1;
    drive_start(1'b0, 2'd2, 1'b1, 32'h0000_0040, 32'h0F0F_0F0F);
    step();
    drive_start(1'b0, 2'd2, 1'b1, 32'h0000_0080, 32'hFFFF_FFFF);
    step();
    start = 1'b0;
    lat = 2;
    while (!eval && lat < 20) begin
      step();
      lat++;
    end
    chk("post_eval", 32'(eval), 32'd1);
    chk("post_latency", 32'(lat), 32'd4);
    chk("post_derr", 32'(derr), 32'd0);
    chk("post_addr_next", addr_next, 32'h0000_0044);
    repeat (4) step();
    chk("post_no_queued_start", 32'(busy), 32'd0);
    chk("post_no_second_eval", 32'(eval), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
